// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared L2 types: burst, set index, perf counter width
package lc3b_types;

    typedef logic [127:0] lc3b_burst;
    typedef logic [4:0]   lc3b_set_l2;
    typedef logic [15:0]  lc3b_perf_count;

    localparam lc3b_perf_count PERF_COUNT_MAX = 16'hFFFF;

    // Saturating increment: holds at the top value instead of wrapping to zero.
    function automatic lc3b_perf_count perf_sat_inc(input lc3b_perf_count value);
        return (value == PERF_COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/l2_perf_counter.sv
// rtl/l2_perf_counter.sv - 16-bit saturating event counter with synchronous clear
module l2_perf_counter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           inc,
    input  logic           clear,
    output lc3b_perf_count count
);

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= perf_sat_inc(count);
        end
    end

endmodule

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - two-way L2 controller FSM: hit service, writeback, allocate
module l2_cache_control
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,

    input  logic           mem_read,
    input  logic           mem_write,
    output logic           mem_resp,

    input  logic           tag0_hit,
    input  logic           tag1_hit,
    input  logic           dirty0,
    input  logic           dirty1,
    input  logic           lru,

    output logic           pmem_read,
    output logic           pmem_write,
    input  logic           pmem_resp,

    output logic           data_load,
    output logic           tag_load,
    output logic           valid_set,
    output logic           dirty_set,
    output logic           dirty_clr,
    output logic           lru_load,
    output logic           lru_in,
    output logic           data_in_sel,
    output logic           addr_sel,

    input  logic           perf_clear,
    output lc3b_perf_count hit_count,
    output lc3b_perf_count miss_count,
    output lc3b_perf_count wb_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state;

    logic request;
    logic any_hit;
    logic victim_dirty;
    logic hit_event;
    logic miss_event;
    logic wb_event;

    assign request      = mem_read | mem_write;
    assign any_hit      = tag0_hit | tag1_hit;
    assign victim_dirty = lru ? dirty1 : dirty0;

    assign hit_event  = (state == S_IDLE) && request && any_hit;
    assign miss_event = (state == S_IDLE) && request && !any_hit;
    assign wb_event   = (state == S_WRITEBACK) && pmem_resp;

    // Miss handling: optional writeback of a dirty victim, then allocate, then back to IDLE
    // where the request is served as an ordinary hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_event) begin
                        state <= victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        state <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs per state plus the IDLE hit terms; everything is forced low while reset is held.
    always_comb begin
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        data_load   = 1'b0;
        tag_load    = 1'b0;
        valid_set   = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        lru_load    = 1'b0;
        lru_in      = 1'b0;
        data_in_sel = 1'b0;
        addr_sel    = 1'b0;
        if (reset_n) begin
            case (state)
                S_IDLE: begin
                    if (request && any_hit) begin
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        // Way 0 wins when both compares fire, so the other way becomes LRU.
                        lru_in   = tag0_hit;
                        if (mem_write) begin
                            data_load = 1'b1;
                            dirty_set = 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                end
                S_ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_load   = 1'b1;
                        data_in_sel = 1'b1;
                        tag_load    = 1'b1;
                        valid_set   = 1'b1;
                        dirty_clr   = 1'b1;
                    end
                end
                default: begin
                    mem_resp = 1'b0;
                end
            endcase
        end
    end

    l2_perf_counter u_hit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit_event),
        .clear   (perf_clear),
        .count   (hit_count)
    );

    l2_perf_counter u_miss_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_event),
        .clear   (perf_clear),
        .count   (miss_count)
    );

    l2_perf_counter u_wb_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wb_event),
        .clear   (perf_clear),
        .count   (wb_count)
    );

endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - scoreboard bench for l2_cache_control
module tb_l2_cache_control;

    // stimulus bit positions
    localparam logic [8:0] PCLR = 9'h100;
    localparam logic [8:0] RD   = 9'h080;
    localparam logic [8:0] WR   = 9'h040;
    localparam logic [8:0] T0   = 9'h020;
    localparam logic [8:0] T1   = 9'h010;
    localparam logic [8:0] D0   = 9'h008;
    localparam logic [8:0] D1   = 9'h004;
    localparam logic [8:0] LRU  = 9'h002;
    localparam logic [8:0] PR   = 9'h001;
    localparam logic [8:0] NONE = 9'h000;

    // control output bit positions
    localparam logic [11:0] O_RESP = 12'h800;
    localparam logic [11:0] O_PRD  = 12'h400;
    localparam logic [11:0] O_PWR  = 12'h200;
    localparam logic [11:0] O_DLD  = 12'h100;
    localparam logic [11:0] O_TLD  = 12'h080;
    localparam logic [11:0] O_VS   = 12'h040;
    localparam logic [11:0] O_DS   = 12'h020;
    localparam logic [11:0] O_DC   = 12'h010;
    localparam logic [11:0] O_LL   = 12'h008;
    localparam logic [11:0] O_LI   = 12'h004;
    localparam logic [11:0] O_DIS  = 12'h002;
    localparam logic [11:0] O_AS   = 12'h001;
    localparam logic [11:0] O_NONE = 12'h000;

    localparam logic [11:0] HIT_R0 = O_RESP | O_LL | O_LI;
    localparam logic [11:0] HIT_R1 = O_RESP | O_LL;
    localparam logic [11:0] HIT_W0 = O_RESP | O_DLD | O_DS | O_LL | O_LI;
    localparam logic [11:0] HIT_W1 = O_RESP | O_DLD | O_DS | O_LL;
    localparam logic [11:0] WB     = O_PWR | O_AS;
    localparam logic [11:0] FILL   = O_PRD | O_DLD | O_DIS | O_TLD | O_VS | O_DC;

    logic        clk;
    logic        reset_n;
    logic        mem_read, mem_write, mem_resp;
    logic        tag0_hit, tag1_hit, dirty0, dirty1, lru;
    logic        pmem_read, pmem_write, pmem_resp;
    logic        data_load, tag_load, valid_set, dirty_set, dirty_clr;
    logic        lru_load, lru_in, data_in_sel, addr_sel;
    logic        perf_clear;
    logic [15:0] hit_count, miss_count, wb_count;

    l2_cache_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_resp    (mem_resp),
        .tag0_hit    (tag0_hit),
        .tag1_hit    (tag1_hit),
        .dirty0      (dirty0),
        .dirty1      (dirty1),
        .lru         (lru),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_resp   (pmem_resp),
        .data_load   (data_load),
        .tag_load    (tag_load),
        .valid_set   (valid_set),
        .dirty_set   (dirty_set),
        .dirty_clr   (dirty_clr),
        .lru_load    (lru_load),
        .lru_in      (lru_in),
        .data_in_sel (data_in_sel),
        .addr_sel    (addr_sel),
        .perf_clear  (perf_clear),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ctl_vec;
    assign ctl_vec = {mem_resp, pmem_read, pmem_write, data_load, tag_load, valid_set,
                      dirty_set, dirty_clr, lru_load, lru_in, data_in_sel, addr_sel};

    logic [59:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [59:0] mon_exp;
    logic [59:0] mon_act;
    string       mon_name;

    // monitor: pops one expected vector per cycle and compares away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {ctl_vec, hit_count, miss_count, wb_count};
            n_vec++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL %s: got ctl=%03h hit=%04h miss=%04h wb=%04h, want ctl=%03h hit=%04h miss=%04h wb=%04h",
                         mon_name, mon_act[59:48], mon_act[47:32], mon_act[31:16], mon_act[15:0],
                         mon_exp[59:48], mon_exp[47:32], mon_exp[31:16], mon_exp[15:0]);
            end
        end
    end

    task automatic step(input logic [8:0] s, input logic [11:0] ec,
                        input logic [15:0] eh, input logic [15:0] em, input logic [15:0] ew,
                        input string nm);
        {perf_clear, mem_read, mem_write, tag0_hit, tag1_hit, dirty0, dirty1, lru, pmem_resp} = s;
        exp_q.push_back({ec, eh, em, ew});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {perf_clear, mem_read, mem_write, tag0_hit, tag1_hit, dirty0, dirty1, lru, pmem_resp} = '0;
        @(posedge clk);
        #1;

        // reset holds every output low even with a hitting request present
        step(RD | T1, O_NONE, 16'd0, 16'd0, 16'd0, "reset_gate");
        reset_n = 1'b1;
        step(NONE, O_NONE, 16'd0, 16'd0, 16'd0, "idle");

        // hits
        step(RD | T1, HIT_R1, 16'd0, 16'd0, 16'd0, "read_hit_w1");
        step(NONE, O_NONE, 16'd1, 16'd0, 16'd0, "hit_count_1");
        step(WR | T0, HIT_W0, 16'd1, 16'd0, 16'd0, "write_hit_w0");
        step(RD | WR | T0 | T1, HIT_W0, 16'd2, 16'd0, 16'd0, "rdwr_bothhit");
        step(RD | T0, HIT_R0, 16'd3, 16'd0, 16'd0, "read_hit_w0");

        // dirty miss: victim way1 dirty, 4-cycle writeback then 4-cycle allocate
        step(RD | D1 | LRU, O_NONE, 16'd4, 16'd0, 16'd0, "dirty_miss");
        step(RD | D1 | LRU, WB, 16'd4, 16'd1, 16'd0, "wb_c1");
        step(RD | D1 | LRU, WB, 16'd4, 16'd1, 16'd0, "wb_c2");
        step(RD | D1 | LRU, WB, 16'd4, 16'd1, 16'd0, "wb_c3");
        step(RD | D1 | LRU | PR, WB, 16'd4, 16'd1, 16'd0, "wb_c4_resp");
        step(RD | D1 | LRU, O_PRD, 16'd4, 16'd1, 16'd1, "alloc_c1");
        step(RD | D1 | LRU, O_PRD, 16'd4, 16'd1, 16'd1, "alloc_c2");
        step(RD | D1 | LRU, O_PRD, 16'd4, 16'd1, 16'd1, "alloc_c3");
        step(RD | D1 | LRU | PR, FILL, 16'd4, 16'd1, 16'd1, "alloc_fill");
        step(RD | T1 | D1 | LRU, HIT_R1, 16'd4, 16'd1, 16'd1, "miss_complete");
        step(NONE, O_NONE, 16'd5, 16'd1, 16'd1, "after_miss");

        // clean miss, request dropped during allocate
        step(RD | D1, O_NONE, 16'd5, 16'd1, 16'd1, "clean_miss");
        step(RD | D1, O_PRD, 16'd5, 16'd2, 16'd1, "drop_alloc_c1");
        step(NONE, O_PRD, 16'd5, 16'd2, 16'd1, "drop_alloc_c2");
        step(PR, FILL, 16'd5, 16'd2, 16'd1, "drop_fill");
        step(NONE, O_NONE, 16'd5, 16'd2, 16'd1, "drop_no_resp");
        step(RD | T0, HIT_R0, 16'd5, 16'd2, 16'd1, "drop_back_idle");

        // way0 dirty but victim is way1 (clean): straight to allocate, then write hit way1
        step(WR | D0 | LRU, O_NONE, 16'd6, 16'd2, 16'd1, "clean_victim");
        step(WR | D0 | LRU | PR, FILL, 16'd6, 16'd3, 16'd1, "fast_fill");
        step(WR | T1, HIT_W1, 16'd6, 16'd3, 16'd1, "write_hit_w1");

        // reset in the middle of a writeback
        step(RD | D0, O_NONE, 16'd7, 16'd3, 16'd1, "dirty_miss_w0");
        step(RD | D0, WB, 16'd7, 16'd4, 16'd1, "wb_before_rst");
        reset_n = 1'b0;
        step(RD | D0, O_NONE, 16'd0, 16'd0, 16'd0, "rst_during_wb");
        reset_n = 1'b1;
        step(RD | T0, HIT_R0, 16'd0, 16'd0, 16'd0, "post_rst_hit");
        step(PCLR, O_NONE, 16'd1, 16'd0, 16'd0, "perf_clear");

        // drive hit_count to saturation
        for (int i = 0; i < 65535; i++) begin
            step(RD | T0, HIT_R0, 16'(i), 16'd0, 16'd0, "sat_ramp");
        end
        step(RD | T0, HIT_R0, 16'hFFFF, 16'd0, 16'd0, "sat_at_max");
        step(RD | T0, HIT_R0, 16'hFFFF, 16'd0, 16'd0, "sat_hold");
        step(PCLR | RD | T0, HIT_R0, 16'hFFFF, 16'd0, 16'd0, "clear_with_hit");
        step(NONE, O_NONE, 16'd0, 16'd0, 16'd0, "clear_wins");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
